// File: rtl/wddl_pipe_reg_pkg.sv
// Shared dual-rail encodings and the per-pair legality check for the WDDL register pipeline.
// Rail pairs are written {t, f}.
package wddl_pipe_reg_pkg;

    localparam logic [1:0] WDDL_PRE  = 2'b00;
    localparam logic [1:0] WDDL_ONE  = 2'b10;
    localparam logic [1:0] WDDL_ZERO = 2'b01;
    localparam logic [1:0] WDDL_ILL  = 2'b11;

    function automatic logic wddl_pair_legal(input logic [1:0] pair);
        logic ok;
        ok = 1'b0;
        case (pair)
            WDDL_ONE, WDDL_ZERO: ok = 1'b1;
            WDDL_PRE, WDDL_ILL:  ok = 1'b0;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wddl_pipe_reg_dr_stage.sv
// One WIDTH-wide dual-rail register stage with its token valid bit.
// The stage loads on ld_i and otherwise holds. Reset returns both rails to precharge.
module wddl_dr_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_t_i,
    input  logic [WIDTH-1:0] d_f_i,
    input  logic             vld_i,
    output logic [WIDTH-1:0] q_t_o,
    output logic [WIDTH-1:0] q_f_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             vld_q, vld_d;

    always_comb begin
        t_d   = t_q;
        f_d   = f_q;
        vld_d = vld_q;
        if (ld_i) begin
            t_d   = d_t_i;
            f_d   = d_f_i;
            vld_d = vld_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q   <= '0;
            f_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            t_q   <= t_d;
            f_q   <= f_d;
            vld_q <= vld_d;
        end
    end

    assign q_t_o = t_q;
    assign q_f_o = f_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/wddl_pipe_reg.sv
// WDDL dual-rail register pipeline with capture enable, input code checking,
// a sticky error flag, and a saturating error counter. Outputs precharge to 00.
module wddl_pipe_reg
    import wddl_pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prechrg_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_t_i,
    input  logic [WIDTH-1:0] d_f_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] q_t_o,
    output logic [WIDTH-1:0] q_f_o,
    output logic             valid_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             cap;
    logic             word_legal;
    logic [WIDTH-1:0] in_t;
    logic [WIDTH-1:0] in_f;

    logic [WIDTH-1:0] st_t [DEPTH];
    logic [WIDTH-1:0] st_f [DEPTH];
    logic             st_v [DEPTH];

    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cap = ~prechrg_i & en_i;

    // An illegal word is squashed to precharge so it can never leak as data downstream.
    always_comb begin
        word_legal = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            word_legal = word_legal & wddl_pair_legal({d_t_i[i], d_f_i[i]});
        end
        in_t = word_legal ? d_t_i : '0;
        in_f = word_legal ? d_f_i : '0;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            wddl_dr_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .ld_i  (cap),
                .d_t_i (in_t),
                .d_f_i (in_f),
                .vld_i (word_legal),
                .q_t_o (st_t[g]),
                .q_f_o (st_f[g]),
                .vld_o (st_v[g])
            );
        end else begin : g_body
            wddl_dr_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .ld_i  (cap),
                .d_t_i (st_t[g-1]),
                .d_f_i (st_f[g-1]),
                .vld_i (st_v[g-1]),
                .q_t_o (st_t[g]),
                .q_f_o (st_f[g]),
                .vld_o (st_v[g])
            );
        end
    end

    // Clear is applied first so a same-cycle illegal capture restarts the count at 1.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (err_clr_i) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
        if (cap && !word_legal) begin
            err_d = 1'b1;
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_t_o     = st_t[DEPTH-1] & {WIDTH{~prechrg_i}};
    assign q_f_o     = st_f[DEPTH-1] & {WIDTH{~prechrg_i}};
    assign valid_o   = st_v[DEPTH-1] & ~prechrg_i;
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_wddl_pipe_reg.sv
// Self-checking bench for wddl_pipe_reg (WIDTH=4, DEPTH=2, CNT_W=4).
// Each evaluate phase holds exactly one posedge; precharge is driven on negedge clk.
module tb_wddl_pipe_reg;

    localparam int unsigned W = 4;
    localparam int unsigned D = 2;
    localparam int unsigned C = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         prechrg;
    logic         en;
    logic [W-1:0] d_t;
    logic [W-1:0] d_f;
    logic         err_clr;
    logic [W-1:0] q_t;
    logic [W-1:0] q_f;
    logic         valid;
    logic         err;
    logic [C-1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0] t;
        logic [W-1:0] f;
        logic         v;
    } tok_t;

    tok_t         pipe[$];
    logic         m_err;
    logic [C-1:0] m_cnt;

    typedef struct {
        logic         en;
        logic [W-1:0] t;
        logic [W-1:0] f;
        logic         clr;
        logic [W-1:0] exp_t;
        logic [W-1:0] exp_f;
        logic         exp_v;
        logic         exp_err;
        logic [C-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    wddl_pipe_reg #(
        .WIDTH (W),
        .DEPTH (D),
        .CNT_W (C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prechrg_i (prechrg),
        .en_i      (en),
        .d_t_i     (d_t),
        .d_f_i     (d_f),
        .err_clr_i (err_clr),
        .q_t_o     (q_t),
        .q_f_o     (q_f),
        .valid_o   (valid),
        .err_o     (err),
        .err_cnt_o (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < int'(D); i++) pipe.push_back('0);
        m_err = 1'b0;
        m_cnt = '0;
    endtask

    // Scoreboard: each capture pushes its expected token; the oldest leaves when it drops off the last stage.
    task automatic model_capture(input logic e, input logic [W-1:0] t, input logic [W-1:0] f,
                                 input logic clr);
        logic lg;
        tok_t tk;
        lg = ((t ^ f) == {W{1'b1}});
        if (clr) begin
            m_err = 1'b0;
            m_cnt = '0;
        end
        if (e) begin
            if (!lg) begin
                m_err = 1'b1;
                if (m_cnt != {C{1'b1}}) m_cnt = m_cnt + 1'b1;
            end
            tk.t = lg ? t : '0;
            tk.f = lg ? f : '0;
            tk.v = lg;
            pipe.push_front(tk);
            void'(pipe.pop_back());
        end
    endtask

    // Evaluate phase: drive at negedge, capture at posedge, leave #1 for sampling.
    task automatic eval_phase(input logic e, input logic [W-1:0] t, input logic [W-1:0] f,
                              input logic clr);
        @(negedge clk);
        prechrg = 1'b0;
        en      = e;
        d_t     = t;
        d_f     = f;
        err_clr = clr;
        @(posedge clk);
        model_capture(e, t, f, clr);
        #1;
    endtask

    // Precharge phase with enable and legal data asserted: nothing may be captured.
    task automatic pre_phase(input string name);
        @(negedge clk);
        prechrg = 1'b1;
        en      = 1'b1;
        d_t     = 4'h9;
        d_f     = 4'h6;
        err_clr = 1'b0;
        #1;
        chk({name, ".pre_qt"}, 32'(q_t), 32'h0);
        chk({name, ".pre_qf"}, 32'(q_f), 32'h0);
        chk({name, ".pre_v"}, 32'(valid), 32'h0);
    endtask

    task automatic chk_model(input string name);
        tok_t tk;
        tk = pipe[D-1];
        chk({name, ".qt"}, 32'(q_t), 32'(tk.t));
        chk({name, ".qf"}, 32'(q_f), 32'(tk.f));
        chk({name, ".v"}, 32'(valid), 32'(tk.v));
        chk({name, ".err"}, 32'(err), 32'(m_err));
        chk({name, ".cnt"}, 32'(err_cnt), 32'(m_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 4'hA, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{1'b1, 4'h3, 4'hC, 1'b0, 4'hA, 4'h5, 1'b1, 1'b0, 4'd0};
        vecs[2] = '{1'b1, 4'h6, 4'h9, 1'b0, 4'h3, 4'hC, 1'b1, 1'b0, 4'd0};
        vecs[3] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h3, 4'hC, 1'b1, 1'b0, 4'd0};
        vecs[4] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h3, 4'hC, 1'b1, 1'b0, 4'd0};
        vecs[5] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h3, 4'hC, 1'b1, 1'b0, 4'd0};
        vecs[6] = '{1'b1, 4'hF, 4'h1, 1'b0, 4'h6, 4'h9, 1'b1, 1'b1, 4'd1};
        vecs[7] = '{1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'd1};
        vecs[8] = '{1'b1, 4'h5, 4'hA, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 4'd1};
        vecs[9] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 4'd0};

        rst_n   = 1'b0;
        prechrg = 1'b0;
        en      = 1'b1;
        d_t     = 4'hA;
        d_f     = 4'h5;
        err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.qt", 32'(q_t), 32'h0);
        chk("rst.qf", 32'(q_f), 32'h0);
        chk("rst.v", 32'(valid), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        chk("rst.cnt", 32'(err_cnt), 32'h0);
        @(negedge clk);
        prechrg = 1'b1;
        rst_n   = 1'b1;

        for (int i = 0; i < 10; i++) begin
            eval_phase(vecs[i].en, vecs[i].t, vecs[i].f, vecs[i].clr);
            chk($sformatf("vec%0d.qt", i), 32'(q_t), 32'(vecs[i].exp_t));
            chk($sformatf("vec%0d.qf", i), 32'(q_f), 32'(vecs[i].exp_f));
            chk($sformatf("vec%0d.v", i), 32'(valid), 32'(vecs[i].exp_v));
            chk($sformatf("vec%0d.err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d.cnt", i), 32'(err_cnt), 32'(vecs[i].exp_cnt));
            pre_phase($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] bad_t;
            bad_t = 4'(i) | 4'h3;
            eval_phase(1'b1, bad_t, 4'h1, 1'b0);
            chk_model($sformatf("sat%0d", i));
            pre_phase($sformatf("sat%0d", i));
        end
        chk("sat.cnt15", 32'(err_cnt), 32'd15);

        eval_phase(1'b1, 4'hC, 4'hC, 1'b1);
        chk("clr_ill.err", 32'(err), 32'h1);
        chk("clr_ill.cnt", 32'(err_cnt), 32'd1);
        chk_model("clr_ill");
        pre_phase("clr_ill");

        eval_phase(1'b1, 4'h9, 4'h6, 1'b0);
        chk_model("fill0");
        pre_phase("fill0");
        eval_phase(1'b1, 4'h1, 4'hE, 1'b0);
        chk_model("fill1");
        chk("fill1.v", 32'(valid), 32'h1);

        // Asynchronous reset mid-evaluate, before the negedge.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.qt", 32'(q_t), 32'h0);
        chk("arst.qf", 32'(q_f), 32'h0);
        chk("arst.v", 32'(valid), 32'h0);
        chk("arst.cnt", 32'(err_cnt), 32'h0);
        @(negedge clk);
        prechrg = 1'b1;
        rst_n   = 1'b1;

        eval_phase(1'b1, 4'h7, 4'h8, 1'b0);
        chk("post.v0", 32'(valid), 32'h0);
        chk_model("post0");
        pre_phase("post0");
        eval_phase(1'b1, 4'h2, 4'hD, 1'b0);
        chk("post.v1", 32'(valid), 32'h1);
        chk("post.qt1", 32'(q_t), 32'h7);
        chk_model("post1");
        pre_phase("post1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
